// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM state
// codes and the select/operation encodings seen by ula_control and branch.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_SUB   = 3'b001;
  localparam logic [2:0] ULA_FUNCT = 3'b010;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  // Where a finished (or rejected) instruction goes: straight into the next
  // fetch while run is requested, otherwise park in IDLE.
  function automatic state_t after_terminal(input logic en);
    return en ? S_FETCH : S_IDLE;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | parked, waits for enable
// FETCH     | read instruction, PC+4 written on mem_ready
// DECODE    | decode opcode, precompute branch target
// MEM_ADDR  | base + imm address for lw/sw
// MEM_READ  | data read, waits mem_ready
// MEM_WB    | load result to rt (terminal)
// MEM_WRITE | data write, waits mem_ready (terminal on ready)
// R_EXEC    | ALU op from funct
// R_WB      | ALU result to rd (terminal)
// BRANCH    | compare and conditional PC update (terminal)
// JUMP      | PC <- jump target (terminal)
// ADDI_EXEC | rs + imm
// ADDI_WB   | result to rt (terminal)
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        RegDst,
  output logic [1:0]  BranchOp,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ula_operation,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  state_t      state_q, state_d;
  logic        retire;
  logic [31:0] instr_count_q;

  assign state       = state_q;
  assign instr_count = instr_count_q;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; retire marks the edge leaving a supported terminal state.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDI_EXEC;
          default:        state_d = after_terminal(enable);
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = after_terminal(enable);
        end
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        retire  = 1'b1;
        state_d = after_terminal(enable);
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: Moore strobes, except FETCH's IR/PC write which follow mem_ready.
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    IRWrite       = 1'b0;
    ALUSrcA       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    BranchOp      = BR_NONE;
    PCSource      = PCSRC_ALU;
    ALUSrcB       = ALUB_REG;
    ula_operation = ULA_ADD;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = ALUB_IMM_SH2;
        illegal_op = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                                      OP_BNE, OP_J, OP_ADDI});
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA       = 1'b1;
        ula_operation = ULA_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ula_operation = ULA_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = PCSRC_ALUOUT;
        BranchOp      = (opcode == OP_BNE) ? BR_BNE : BR_BEQ;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDI_WB:   RegWrite = 1'b1;
      default:     ;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      instr_count_q <= '0;
    else if (retire) instr_count_q <= instr_count_q + 32'd1;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: the driver walks each instruction through its
// expected cycle sequence, queuing one expected record per cycle; a monitor on
// the falling edge pops and compares against the DUT.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  BranchOp, PCSource, ALUSrcB;
  logic [2:0]  ula_operation;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .BranchOp(BranchOp), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ula_operation(ula_operation), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  logic [18:0] act_ctl;
  assign act_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, ALUSrcA, RegWrite, RegDst, BranchOp, PCSource,
                    ALUSrcB, ula_operation};

  typedef struct {
    logic [3:0]  st;
    logic [18:0] ctl;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_cnt = 32'd0;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                         T_BEQ = 6'b000100, T_BNE = 6'b000101, T_J = 6'b000010,
                         T_ADDI = 6'b001000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-state strobe table, straight from the state descriptions.
  function automatic logic [18:0] exp_ctl(input int st, input logic [5:0] op, input logic mr);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
    logic asa = 0, rw = 0, rd = 0;
    logic [1:0] bop = 0, psrc = 0, asb = 0;
    logic [2:0] ula = 0;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; ula = 3'b010; end
      8:  begin rw = 1; rd = 1; end
      9:  begin asa = 1; ula = 3'b001; pcwc = 1; psrc = 2'b01;
                bop = (op == T_BNE) ? 2'b10 : 2'b01; end
      10: begin pcw = 1; psrc = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, bop, psrc, asb, ula};
  endfunction

  // Drive one cycle's inputs, queue what the DUT should show, step to the next cycle.
  task automatic cycle(input int st, input logic mr, input logic en, input logic ill);
    exp_t e;
    mem_ready = mr;
    enable    = en;
    e.st  = 4'(st);
    e.ctl = exp_ctl(st, opcode, mr);
    e.ill = ill;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Assumes the DUT enters FETCH on the next edge-to-edge cycle.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input logic en_next);
    opcode = op;
    for (int i = 0; i < wf; i++) cycle(1, 1'b0, rb(), 1'b0);
    cycle(1, 1'b1, rb(), 1'b0);
    case (op)
      T_R:    begin cycle(2, rb(), rb(), 0); cycle(7, rb(), rb(), 0);
                    cycle(8, rb(), en_next, 0); m_cnt++; end
      T_LW:   begin cycle(2, rb(), rb(), 0); cycle(3, rb(), rb(), 0);
                    for (int i = 0; i < wm; i++) cycle(4, 1'b0, rb(), 0);
                    cycle(4, 1'b1, rb(), 0);
                    cycle(5, rb(), en_next, 0); m_cnt++; end
      T_SW:   begin cycle(2, rb(), rb(), 0); cycle(3, rb(), rb(), 0);
                    for (int i = 0; i < wm; i++) cycle(6, 1'b0, rb(), 0);
                    cycle(6, 1'b1, en_next, 0); m_cnt++; end
      T_BEQ, T_BNE: begin cycle(2, rb(), rb(), 0); cycle(9, rb(), en_next, 0); m_cnt++; end
      T_J:    begin cycle(2, rb(), rb(), 0); cycle(10, rb(), en_next, 0); m_cnt++; end
      T_ADDI: begin cycle(2, rb(), rb(), 0); cycle(11, rb(), rb(), 0);
                    cycle(12, rb(), en_next, 0); m_cnt++; end
      default: cycle(2, rb(), en_next, 1'b1);
    endcase
  endtask

  // Parked cycles; the last one requests run so FETCH follows.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n - 1; i++) cycle(0, rb(), 1'b0, 1'b0);
    cycle(0, rb(), 1'b1, 1'b0);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return T_R;
      1: return T_LW;
      2: return T_SW;
      3: return T_BEQ;
      4: return T_BNE;
      5: return T_J;
      6: return T_ADDI;
      default: return $urandom_range(0, 1) ? 6'b111111 : 6'b001100;
    endcase
  endfunction

  // Monitor: compare each cycle against the queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("strobes", 32'(act_ctl), 32'(e.ctl));
      check("illegal_op", 32'(illegal_op), 32'(e.ill));
      check("instr_count", instr_count, e.cnt);
    end else if (state !== 4'd0) begin
      check("unexpected_activity", 32'(state), 32'd0);
    end
  end

  initial begin
    logic en_next;
    logic [31:0] cnt_before;

    // Reset held with enable high: parked, everything zero.
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'(act_ctl), 32'd0);
    check("reset_count", instr_count, 32'd0);
    reset = 1'b1;
    cycle(0, 1'b1, 1'b1, 1'b0);

    // Directed back-to-back sequence with memory always ready.
    run_instr(T_R,    0, 0, 1'b1);
    run_instr(T_LW,   0, 0, 1'b1);
    run_instr(T_SW,   0, 0, 1'b1);
    run_instr(T_BEQ,  0, 0, 1'b1);
    run_instr(T_J,    0, 0, 1'b1);
    run_instr(T_ADDI, 0, 0, 1'b1);
    check("count_after_six", instr_count, 32'd6);

    // lw stalled 3 cycles in FETCH and 2 in MEM_READ.
    run_instr(T_LW, 3, 2, 1'b1);

    // Unsupported opcode: pulse in DECODE, straight back to FETCH, not counted.
    cnt_before = m_cnt;
    run_instr(6'b111111, 0, 0, 1'b1);
    check("illegal_not_counted", instr_count, cnt_before);

    run_instr(T_BNE, 1, 0, 1'b1);

    // Randomized traffic with stalls and idle gaps.
    for (int n = 0; n < 60; n++) begin
      en_next = ($urandom_range(0, 3) != 0);
      run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3), en_next);
      if (!en_next) idle_cycles($urandom_range(1, 3));
    end

    // Reset in the middle of a stalled MEM_READ.
    opcode = T_LW;
    cycle(1, 1'b1, 1'b1, 1'b0);
    cycle(2, rb(), 1'b1, 1'b0);
    cycle(3, rb(), 1'b1, 1'b0);
    cycle(4, 1'b0, 1'b1, 1'b0);
    check("pre_reset_state", 32'(state), 32'd4);
    #2 reset = 1'b0;
    enable = 1'b0;
    #1;
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_strobes", 32'(act_ctl), 32'd0);
    check("async_reset_count", instr_count, 32'd0);
    m_cnt = 32'd0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Counter wrap: preload all-ones while parked, then retire one jump.
    dut.instr_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cycle(0, rb(), 1'b0, 1'b0);
    idle_cycles(1);
    run_instr(T_J, 0, 0, 1'b0);
    cycle(0, rb(), 1'b0, 1'b0);
    check("wrap_count", instr_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
